// File: rtl/patch_pkg.sv
// Shared pixel/FSM definitions for the patch loader and the patchifier blocks.
package patch_pkg;

    localparam int unsigned CHANNEL_SIZE = 8;
    localparam int unsigned NUM_CHANNELS = 3;
    localparam int unsigned PIXEL_WIDTH  = CHANNEL_SIZE * NUM_CHANNELS;

    typedef logic [PIXEL_WIDTH-1:0] pixel_t;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        LOAD    = 2'd1,
        PRESENT = 2'd2
    } state_t;

    // Index width for n entries, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/patch_loader_if.sv
// Pixel stream in, patch out: the loader is the slave, its environment the master.
interface patch_loader_if
    import patch_pkg::*;
#(
    parameter int unsigned PATCH_SIZE = 16,
    parameter int unsigned IMG_WIDTH  = 64,
    parameter int unsigned IMG_HEIGHT = 64
);

    localparam int unsigned W_COL = clog2_min1(IMG_WIDTH / PATCH_SIZE);
    localparam int unsigned W_ROW = clog2_min1(IMG_HEIGHT / PATCH_SIZE);

    logic             pix_valid;
    pixel_t           pix_data;
    logic             pix_ready;
    logic             patch_valid;
    logic             patch_ready;
    pixel_t           patch_cache [PATCH_SIZE][PATCH_SIZE];
    logic [W_ROW-1:0] patch_row;
    logic [W_COL-1:0] patch_col;
    logic             patch_last;

    modport master (
        output pix_valid, pix_data, patch_ready,
        input  pix_ready, patch_valid, patch_cache, patch_row, patch_col, patch_last
    );

    modport slave (
        input  pix_valid, pix_data, patch_ready,
        output pix_ready, patch_valid, patch_cache, patch_row, patch_col, patch_last
    );

endinterface

// File: rtl/patch_strip_buffer.sv
// PATCH_SIZE-line strip store with one pixel write port and a square window read.
module patch_strip_buffer
    import patch_pkg::*;
#(
    parameter  int unsigned PATCH_SIZE = 16,
    parameter  int unsigned IMG_WIDTH  = 64,
    localparam int unsigned W_X        = clog2_min1(IMG_WIDTH),
    localparam int unsigned W_LINE     = clog2_min1(PATCH_SIZE)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [W_LINE-1:0] i_line,
    input  logic [W_X-1:0]    i_x,
    input  pixel_t            i_data,
    input  logic [W_X-1:0]    i_col_base,
    output pixel_t            o_window [PATCH_SIZE][PATCH_SIZE]
);

    pixel_t r_mem [PATCH_SIZE][IMG_WIDTH];

    // Write one accepted pixel; contents are never cleared, only overwritten.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_line][i_x] <= i_data;
        end
    end

    // Window of all strip lines at columns i_col_base .. i_col_base+PATCH_SIZE-1.
    for (genvar r = 0; r < PATCH_SIZE; r++) begin : g_row
        for (genvar c = 0; c < PATCH_SIZE; c++) begin : g_col
            assign o_window[r][c] = r_mem[r][i_col_base + W_X'(c)];
        end
    end

endmodule

// File: rtl/patch_loader.sv
// Collects a raster pixel stream into strips and presents them one patch at a time.
module patch_loader
    import patch_pkg::*;
#(
    parameter int unsigned PATCH_SIZE = 16,
    parameter int unsigned IMG_WIDTH  = 64,
    parameter int unsigned IMG_HEIGHT = 64
) (
    input  logic           clk,
    input  logic           reset,
    patch_loader_if.slave  bus
);

    localparam int unsigned COLS   = IMG_WIDTH / PATCH_SIZE;
    localparam int unsigned ROWS   = IMG_HEIGHT / PATCH_SIZE;
    localparam int unsigned W_X    = clog2_min1(IMG_WIDTH);
    localparam int unsigned W_LINE = clog2_min1(PATCH_SIZE);
    localparam int unsigned W_COL  = clog2_min1(COLS);
    localparam int unsigned W_ROW  = clog2_min1(ROWS);

    localparam logic [W_X-1:0]    LAST_X    = W_X'(IMG_WIDTH - 1);
    localparam logic [W_LINE-1:0] LAST_LINE = W_LINE'(PATCH_SIZE - 1);
    localparam logic [W_COL-1:0]  LAST_COL  = W_COL'(COLS - 1);
    localparam logic [W_ROW-1:0]  LAST_ROW  = W_ROW'(ROWS - 1);

    if ((IMG_WIDTH % PATCH_SIZE) != 0) begin : g_bad_width
        $error("IMG_WIDTH must be an integer multiple of PATCH_SIZE");
    end
    if ((IMG_HEIGHT % PATCH_SIZE) != 0) begin : g_bad_height
        $error("IMG_HEIGHT must be an integer multiple of PATCH_SIZE");
    end

    state_t            r_state;
    state_t            w_next_state;
    logic              w_pix_accept;
    logic              w_strip_done;
    logic [W_X-1:0]    r_x;
    logic [W_LINE-1:0] r_line;
    logic [W_ROW-1:0]  r_patch_row;
    logic [W_COL-1:0]  r_patch_col;
    logic              r_patch_last;
    pixel_t            r_patch_cache [PATCH_SIZE][PATCH_SIZE];
    pixel_t            w_window      [PATCH_SIZE][PATCH_SIZE];
    logic [W_X-1:0]    w_col_base;

    assign w_col_base = W_X'(32'(r_patch_col) * PATCH_SIZE);

    patch_strip_buffer #(
        .PATCH_SIZE (PATCH_SIZE),
        .IMG_WIDTH  (IMG_WIDTH)
    ) u_strip (
        .clk        (clk),
        .i_we       (w_pix_accept),
        .i_line     (r_line),
        .i_x        (r_x),
        .i_data     (bus.pix_data),
        .i_col_base (w_col_base),
        .o_window   (w_window)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: fill a strip, then load/present each of its patches in turn.
    always_comb begin
        w_next_state = r_state;
        w_pix_accept = 1'b0;
        w_strip_done = 1'b0;
        case (r_state)
            FILL: begin
                w_pix_accept = bus.pix_valid;
                w_strip_done = w_pix_accept && (r_line == LAST_LINE) && (r_x == LAST_X);
                if (w_strip_done) begin
                    w_next_state = LOAD;
                end
            end
            LOAD: begin
                w_next_state = PRESENT;
            end
            PRESENT: begin
                if (bus.patch_ready) begin
                    w_next_state = (r_patch_col < LAST_COL) ? LOAD : FILL;
                end
            end
            default: begin
                w_next_state = FILL;
            end
        endcase
    end

    // Strip write position: x runs along a line, line advances on x wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x    <= '0;
            r_line <= '0;
        end else if (w_pix_accept) begin
            if (r_x == LAST_X) begin
                r_x    <= '0;
                r_line <= (r_line == LAST_LINE) ? '0 : r_line + W_LINE'(1);
            end else begin
                r_x <= r_x + W_X'(1);
            end
        end
    end

    // Patch capture and grid position; held while the patch waits for the consumer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_patch_row  <= '0;
            r_patch_col  <= '0;
            r_patch_last <= 1'b0;
            for (int r = 0; r < int'(PATCH_SIZE); r++) begin
                for (int c = 0; c < int'(PATCH_SIZE); c++) begin
                    r_patch_cache[r][c] <= '0;
                end
            end
        end else if (r_state == LOAD) begin
            r_patch_cache <= w_window;
            r_patch_last  <= (r_patch_row == LAST_ROW) && (r_patch_col == LAST_COL);
        end else if ((r_state == PRESENT) && bus.patch_ready) begin
            r_patch_last <= 1'b0;
            if (r_patch_col < LAST_COL) begin
                r_patch_col <= r_patch_col + W_COL'(1);
            end else begin
                r_patch_col <= '0;
                r_patch_row <= (r_patch_row == LAST_ROW) ? '0 : r_patch_row + W_ROW'(1);
            end
        end
    end

    assign bus.pix_ready   = (r_state == FILL);
    assign bus.patch_valid = (r_state == PRESENT);
    assign bus.patch_cache = r_patch_cache;
    assign bus.patch_row   = r_patch_row;
    assign bus.patch_col   = r_patch_col;
    assign bus.patch_last  = r_patch_last;

endmodule

// File: tb/tb_patch_loader.sv
// Bench for patch_loader on a 4x4 image with 2x2 patches.
module tb_patch_loader;
    import patch_pkg::*;

    localparam int unsigned PS   = 2;
    localparam int unsigned IW   = 4;
    localparam int unsigned IH   = 4;
    localparam int          PCOL = IW / PS;
    localparam int          PROW = IH / PS;
    localparam int          PPF  = PCOL * PROW;
    localparam int          NPIX = IW * IH;

    typedef struct {
        logic pv;
        logic pr;
        logic e_rdy;
        logic e_val;
        logic e_last;
        int   e_row;
        int   e_col;
    } vec_t;

    logic clk;
    logic reset;

    patch_loader_if #(.PATCH_SIZE(PS), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)) bus ();

    patch_loader #(.PATCH_SIZE(PS), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    pixel_t hist [$];
    int     n_patch = 0;
    logic   prev_valid = 1'b0;
    logic   prev_ready = 1'b0;
    int     prev_row, prev_col;
    logic   prev_last;
    pixel_t prev_cache [PS][PS];
    bit     use_rand = 1'b0;
    int     salt = 0;
    pixel_t pool [256];
    vec_t   tbl [25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_cache(input int a, input int b, input int c, input int d);
        chk("cache00", 32'(bus.patch_cache[0][0]), 32'(a));
        chk("cache01", 32'(bus.patch_cache[0][1]), 32'(b));
        chk("cache10", 32'(bus.patch_cache[1][0]), 32'(c));
        chk("cache11", 32'(bus.patch_cache[1][1]), 32'(d));
    endtask

    // Reference: patch n since reset is frame n/PPF, grid slot n%PPF, cut from the raster history.
    task automatic check_patch();
        int k, q, pr, pc, idx;
        k  = n_patch / PPF;
        q  = n_patch % PPF;
        pr = q / PCOL;
        pc = q % PCOL;
        chk("patch_row", 32'(bus.patch_row), 32'(pr));
        chk("patch_col", 32'(bus.patch_col), 32'(pc));
        chk("patch_last", 32'(bus.patch_last), 32'((pr == PROW - 1) && (pc == PCOL - 1)));
        for (int i = 0; i < int'(PS); i++) begin
            for (int j = 0; j < int'(PS); j++) begin
                idx = k * NPIX + (pr * int'(PS) + i) * int'(IW) + pc * int'(PS) + j;
                chk("patch_src_avail", 32'(hist.size() > idx), 32'd1);
                if (hist.size() > idx) begin
                    chk("patch_pixel", 32'(bus.patch_cache[i][j]), 32'(hist[idx]));
                end
            end
        end
    endtask

    // Monitor: record accepted pixels, check each new patch and hold stability.
    always @(negedge clk) begin
        if (reset) begin
            hist.delete();
            n_patch    = 0;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (bus.pix_valid && bus.pix_ready) begin
                hist.push_back(bus.pix_data);
            end
            if (bus.patch_valid && !prev_valid) begin
                check_patch();
                n_patch++;
            end
            if (bus.patch_valid && prev_valid && !prev_ready) begin
                chk("hold_row", 32'(bus.patch_row), 32'(prev_row));
                chk("hold_col", 32'(bus.patch_col), 32'(prev_col));
                chk("hold_last", 32'(bus.patch_last), 32'(prev_last));
                for (int i = 0; i < int'(PS); i++) begin
                    for (int j = 0; j < int'(PS); j++) begin
                        chk("hold_cache", 32'(bus.patch_cache[i][j]), 32'(prev_cache[i][j]));
                    end
                end
            end
            if (!bus.patch_valid) begin
                chk("last_low_idle", 32'(bus.patch_last), 32'd0);
            end
            prev_valid = bus.patch_valid;
            prev_ready = bus.patch_ready;
            prev_row   = int'(bus.patch_row);
            prev_col   = int'(bus.patch_col);
            prev_last  = bus.patch_last;
            for (int i = 0; i < int'(PS); i++) begin
                for (int j = 0; j < int'(PS); j++) begin
                    prev_cache[i][j] = bus.patch_cache[i][j];
                end
            end
        end
    end

    // Upstream holds the offered pixel until taken: data is indexed by accepted count.
    task automatic drive(input logic pv, input logic pr);
        bus.pix_valid   = pv;
        bus.patch_ready = pr;
        bus.pix_data    = use_rand ? pool[(hist.size() + salt) % 256] : pixel_t'(hist.size());
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        bus.pix_valid   = 1'b0;
        bus.patch_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_stream(input int target, input int vpct, input int rpct, input int budget);
        int c;
        c = 0;
        while (n_patch < target && c < budget) begin
            drive(1'($urandom_range(99) < vpct), 1'($urandom_range(99) < rpct));
            @(negedge clk);
            @(posedge clk);
            #1;
            c++;
        end
        chk("stream_reached_target", 32'(n_patch >= target), 32'd1);
    endtask

    function automatic vec_t mk(logic pv, logic pr, logic rdy, logic val, logic last, int row, int col);
        vec_t v;
        v.pv = pv; v.pr = pr; v.e_rdy = rdy; v.e_val = val; v.e_last = last;
        v.e_row = row; v.e_col = col;
        return v;
    endfunction

    initial begin
        int  c;
        logic seen;

        // Cycle-by-cycle expectation for one frame streamed back to back after reset.
        for (int i = 0; i < 8; i++) tbl[i] = mk(1, 1, 1, 0, 0, 0, 0);
        tbl[8]  = mk(1, 1, 0, 0, 0, 0, 0);
        tbl[9]  = mk(1, 1, 0, 1, 0, 0, 0);
        tbl[10] = mk(1, 1, 0, 0, 0, 0, 1);
        tbl[11] = mk(1, 1, 0, 1, 0, 0, 1);
        for (int i = 12; i < 20; i++) tbl[i] = mk(1, 1, 1, 0, 0, 1, 0);
        tbl[20] = mk(1, 1, 0, 0, 0, 1, 0);
        tbl[21] = mk(1, 1, 0, 1, 0, 1, 0);
        tbl[22] = mk(1, 1, 0, 0, 0, 1, 1);
        tbl[23] = mk(1, 1, 0, 1, 1, 1, 1);
        tbl[24] = mk(0, 1, 1, 0, 0, 0, 0);

        for (int i = 0; i < 256; i++) pool[i] = pixel_t'($urandom);

        reset           = 1'b1;
        bus.pix_valid   = 1'b0;
        bus.patch_ready = 1'b0;
        bus.pix_data    = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state.
        drive(0, 0);
        @(negedge clk);
        chk("rst_pix_ready", 32'(bus.pix_ready), 32'd1);
        chk("rst_patch_valid", 32'(bus.patch_valid), 32'd0);
        chk("rst_patch_last", 32'(bus.patch_last), 32'd0);
        chk("rst_patch_row", 32'(bus.patch_row), 32'd0);
        chk("rst_patch_col", 32'(bus.patch_col), 32'd0);
        chk_cache(0, 0, 0, 0);
        @(posedge clk);
        #1;

        // Directed frame: timing, bubble, ordering and last flag.
        for (int v = 0; v < 25; v++) begin
            drive(tbl[v].pv, tbl[v].pr);
            @(negedge clk);
            chk("tbl_pix_ready", 32'(bus.pix_ready), 32'(tbl[v].e_rdy));
            chk("tbl_patch_valid", 32'(bus.patch_valid), 32'(tbl[v].e_val));
            chk("tbl_patch_last", 32'(bus.patch_last), 32'(tbl[v].e_last));
            chk("tbl_patch_row", 32'(bus.patch_row), 32'(tbl[v].e_row));
            chk("tbl_patch_col", 32'(bus.patch_col), 32'(tbl[v].e_col));
            if (v == 9) chk_cache(0, 1, 4, 5);
            if (v == 23) chk_cache(10, 11, 14, 15);
            @(posedge clk);
            #1;
        end
        chk("tbl_patch_count", 32'(n_patch), 32'd4);

        // Consumer stalls on the first patch while upstream keeps offering pixel 8.
        do_reset();
        c = 0;
        seen = 1'b0;
        while (!seen && c < 40) begin
            drive(1, 0);
            @(negedge clk);
            seen = bus.patch_valid;
            @(posedge clk);
            #1;
            c++;
        end
        chk("stall_valid_seen", 32'(seen), 32'd1);
        for (int i = 0; i < 10; i++) begin
            drive(1, 0);
            @(negedge clk);
            chk("stall_pix_ready", 32'(bus.pix_ready), 32'd0);
            chk("stall_patch_valid", 32'(bus.patch_valid), 32'd1);
            chk("stall_accepted", 32'(hist.size()), 32'd8);
            @(posedge clk);
            #1;
        end
        chk_cache(0, 1, 4, 5);
        run_stream(4, 100, 100, 200);

        // Random input gaps, then further frames with no reset and a random consumer.
        do_reset();
        run_stream(4, 50, 100, 400);
        run_stream(12, 60, 50, 2000);

        // Reset mid-strip, then a full frame of fresh random data.
        do_reset();
        use_rand = 1'b1;
        salt = 37;
        c = 0;
        while (hist.size() < 5 && c < 20) begin
            drive(1, 1);
            @(negedge clk);
            @(posedge clk);
            #1;
            c++;
        end
        chk("partial_accepted", 32'(hist.size()), 32'd5);
        do_reset();
        salt = 151;
        run_stream(4, 100, 100, 200);
        chk("post_reset_patches", 32'(n_patch), 32'd4);

        drive(0, 0);
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/patch_loader.md
PATCH_LOADER -- requirements
Module: patch_loader

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter CHANNEL_SIZE, 8, bits per colour channel.
REQ-003 Parameter NUM_CHANNELS, 3, channels per pixel (RGB).
REQ-004 Parameter PIXEL_WIDTH, CHANNEL_SIZE*NUM_CHANNELS, bits per pixel.
REQ-005 Parameter PATCH_SIZE, 16, patch edge length in pixels.
REQ-006 Parameters IMG_WIDTH and IMG_HEIGHT, default 64 each, image size in pixels; each SHALL be an integer multiple of PATCH_SIZE (elaboration error otherwise).
REQ-007 clk  input  1  clock; all state updates on its rising edge.
REQ-008 reset  input  1  synchronous active-high reset.
REQ-009 pix_valid  input  1  raster-order pixel present.
REQ-010 pix_data  input  PIXEL_WIDTH  pixel value.
REQ-011 pix_ready  output  1  block accepts a pixel this cycle.
REQ-012 patch_valid  output  1  patch_cache holds a complete patch.
REQ-013 patch_ready  input  1  downstream patchifier is taking the patch (tied to patchifier state == IDLE).
REQ-014 patch_cache  output  [PIXEL_WIDTH-1:0] x [PATCH_SIZE][PATCH_SIZE]  patch as [row][col], which feeds the patchifier patch_cache input directly.
REQ-015 patch_row, patch_col  output  $clog2 of the patch count per column/row (min 1)  grid position of the current patch.
REQ-016 patch_last  output  1  current patch is the final (bottom-right) patch of the frame.

Function
REQ-017 A pixel SHALL be accepted only in a cycle with pix_valid && pix_ready.
REQ-018 The FSM SHALL have states FILL, LOAD and PRESENT, and the reset state SHALL be FILL.
REQ-019 pix_ready SHALL be 1 only in FILL; it SHALL be combinational from state.
REQ-020 FILL SHALL store accepted pixels in a PATCH_SIZE x IMG_WIDTH strip buffer at [line][x], where x counts 0..IMG_WIDTH-1 and line counts 0..PATCH_SIZE-1, and x wraps to 0 with line incrementing.
REQ-021 When the last pixel of a strip is accepted (line=PATCH_SIZE-1, x=IMG_WIDTH-1) at cycle T, the state SHALL be LOAD at T+1, and x and line SHALL wrap to 0.
REQ-022 LOAD SHALL copy strip columns patch_col*PATCH_SIZE..+PATCH_SIZE-1 into patch_cache and go to PRESENT, so patch_valid=1 at T+2.
REQ-023 In PRESENT, patch_valid SHALL be 1, and patch_cache, patch_row, patch_col and patch_last SHALL be held stable until patch_ready=1.
REQ-024 On PRESENT && patch_ready, if patch_col < IMG_WIDTH/PATCH_SIZE-1, then patch_col SHALL increment and the next state SHALL be LOAD (one-cycle bubble, patch_valid=0).
REQ-025 Otherwise on PRESENT && patch_ready, patch_col SHALL go to 0, the next state SHALL be FILL, and patch_row SHALL increment, wrapping to 0 after IMG_HEIGHT/PATCH_SIZE-1.
REQ-026 patch_last SHALL equal (patch_row == last row index && patch_col == last column index) while patch_valid=1, and 0 otherwise.
REQ-027 pix_valid asserted outside FILL SHALL be ignored, with no pixel lost or double-counted; the upstream holds the pixel.
REQ-028 Consecutive frames SHALL need no reset; after the last patch of a frame is taken, the next accepted pixel is pixel (0,0) of the new frame.
REQ-029 patch_ready while patch_valid=0 SHALL have no effect.

Reset
REQ-030 On reset, outputs SHALL be: patch_valid=0, patch_last=0, patch_row=0, patch_col=0, patch_cache all zero, and pix_ready=1 from the following cycle.
REQ-031 On reset, x and line SHALL be 0; strip buffer contents need not be cleared.
REQ-032 Reset asserted mid-strip or mid-PRESENT SHALL abort the frame; partially filled data SHALL never be emitted.

Structure
REQ-033 CHANNEL_SIZE, NUM_CHANNELS, PIXEL_WIDTH and the FSM state enum typedef SHALL live in shared package patch_pkg, which is also used by the patchifier blocks.
REQ-034 The strip buffer SHALL be the single sub-module patch_strip_buffer, with a write port (line, x, data) and a PATCH_SIZE x PATCH_SIZE window read at a column offset.

Verification (PATCH_SIZE=2, IMG_WIDTH=IMG_HEIGHT=4, pix_data = raster index)
REQ-035 Reset then stream 16 pixels with patch_ready=1 -> four patches in order (0,0),(0,1),(1,0),(1,1).
  - First patch_cache = {{0,1},{4,5}}.
  - Last patch_cache = {{10,11},{14,15}}, with patch_last=1 on that patch only.
REQ-036 Hold patch_ready=0 for 10 cycles on the first patch -> patch_valid and patch_cache stay stable, pix_ready=0 throughout, and pix_valid=1 pixel 8 is not consumed.
REQ-037 Last pixel of strip 0 accepted at cycle T -> patch_valid rises at T+2, and patch_valid is 0 for exactly one cycle between patch (0,0) and patch (0,1).
REQ-038 Random pix_valid gaps (50%) -> output identical to REQ-035.
REQ-039 Assert reset after 5 pixels, then stream a full frame -> the first patch is {{0,1},{4,5}} of the new data, and no stale patch appears.
REQ-040 Two back-to-back frames -> the second frame's patch (0,0) is correct and patch_row wraps from 1 to 0.
